// File: rtl/wb_multi_port_arbiter.sv
// wb_multi_port_arbiter: merges NUM_PORTS core req/ack channels onto one Wishbone B4 classic master
module wb_multi_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic [NUM_PORTS-1:0]              ack_o,
  output logic [NUM_PORTS-1:0]              err_o,
  output logic                              wb_cyc_o,
  output logic                              wb_stb_o,
  output logic                              wb_we_o,
  output logic [ADDR_WIDTH-1:0]             wb_addr_o,
  output logic [DATA_WIDTH-1:0]             wb_data_o,
  output logic [DATA_WIDTH/8-1:0]           wb_sel_o,
  input  logic [DATA_WIDTH-1:0]             wb_data_i,
  input  logic                              wb_ack_i,
  input  logic                              wb_err_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int GW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                 st_q, st_d;
  logic [GW-1:0]          ptr_q, ptr_d, g_q, g_d, pick, idx;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   cyc_q, cyc_d, we_q, we_d, timeout;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdat_q, wdat_d, rdata_q, rdata_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d, err_q, err_d;
  int                     base;
  assign base    = ARB_MODE != 0 ? int'(ptr_q) + 1 : 0;
  assign timeout = TIMEOUT_CYCLES != 0 && int'(cnt_q) + 1 == TIMEOUT_CYCLES;
  // descending scan: the last hit is the first port in search order
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = GW'((base + i) % NUM_PORTS);
      if (req_i[idx]) pick = idx;
    end
  end
  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = '0;
    case (st_q)
      IDLE: if (|req_i) begin
        st_d   = BUSY;
        ptr_d  = pick;
        g_d    = pick;
        cnt_d  = '0;
        cyc_d  = 1'b1;
        we_d   = we_i[pick];
        addr_d = addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        wdat_d = wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
        sel_d  = sel_i[int'(pick)*SW +: SW];
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (wb_ack_i || wb_err_i || timeout) begin
          st_d       = RESP;
          cyc_d      = 1'b0;
          rdata_d    = (wb_ack_i || wb_err_i) ? wb_data_i : '0;
          ack_d[g_q] = 1'b1;
          err_d[g_q] = wb_err_i || !wb_ack_i;
        end
      end
      RESP: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q    <= IDLE;
      ptr_q   <= GW'(NUM_PORTS - 1);
      g_q     <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_data_o = wdat_q;
  assign wb_sel_o  = sel_q;
  assign rdata_o   = rdata_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
endmodule

// File: doc/wb_multi_port_arbiter.md
Name: wb_multi_port_arbiter

Overview:
- Parametrised successor to the fixed two-bus core hookup: merges NUM_PORTS core-side req/ack channels onto one Wishbone B4 classic master port toward the Controller.
- Instruction and data ports of a core share one memory bus when the second memory bus is disabled. Multi-port cores are supported without per-core glue.
- Adds a selectable arbitration policy, byte selects, bus-error propagation and a watchdog timeout.

Parameters:
- NUM_PORTS, 2, number of core-side request channels (1..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 255, Wishbone cycles allowed before a forced error completion; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NUM_PORTS  per-port request; held high until the matching ack_o
- we_i  in  NUM_PORTS  per-port write enable
- addr_i  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata_i  in  NUM_PORTS*DATA_WIDTH  packed write data
- sel_i  in  NUM_PORTS*DATA_WIDTH/8  packed byte selects
- rdata_o  out  DATA_WIDTH  read data, shared by all ports, valid with ack_o
- ack_o  out  NUM_PORTS  one-cycle completion pulse per port
- err_o  out  NUM_PORTS  one-cycle error flag, coincident with ack_o
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control
- wb_addr_o  out  ADDR_WIDTH; wb_data_o  out  DATA_WIDTH; wb_sel_o  out  DATA_WIDTH/8
- wb_data_i  in  DATA_WIDTH; wb_ack_i  in  1; wb_err_i  in  1

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, FSM=IDLE, round-robin pointer=NUM_PORTS-1, timeout counter=0. Reset mid-transaction drops wb_cyc_o/wb_stb_o immediately. No ack is issued for the aborted transfer.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req_i bit is set, the arbiter picks grant g and latches we/addr/wdata/sel of port g into the wb_* registers. Next state BUSY; wb_cyc_o=wb_stb_o=1 from the next cycle.
- Fixed mode: g = lowest set index.
- Round-robin mode: search starts at pointer+1 modulo NUM_PORTS; pointer<=g on grant.
- BUSY: wb_* outputs held stable. The counter increments each cycle.
  - On wb_ack_i or wb_err_i: cyc/stb cleared at that edge, rdata_o<=wb_data_i, ack_o[g]<=1, err_o[g]<=wb_err_i. Next state RESP.
  - wb_ack_i and wb_err_i together count as an error.
  - Counter reaching TIMEOUT_CYCLES with no ack: cyc/stb cleared, rdata_o<=0, ack_o[g]=err_o[g]=1. Next state RESP.
- RESP: ack_o/err_o high for exactly this cycle, then cleared. req_i is ignored, because the requester still holds its completed request. Next state IDLE, counter cleared.
- Minimum latency with a zero-wait slave: req sampled at cycle 0, stb at cycle 1, ack_o at cycle 2, next grant sampled at cycle 3.
- A req_i that falls while its transfer is in BUSY does not abort it; the transfer completes and the ack pulse is still issued.
- req_i/addr_i of non-granted ports may change freely. Only values latched at grant are used.
- Write data is never modified. rdata_o holds its last value until the next completion.
- NUM_PORTS=1: arbiter degenerates to pass-through with the same timing.

Test Plan:
- Single read on port 0, slave acks in 1 cycle with 0xCAFEBABE -> wb_stb_o high for 1 cycle, ack_o=2'b01 pulse at cycle 2, rdata_o=0xCAFEBABE, err_o=0.
- Write on port 1, addr 0x100, data 0x12345678, sel 4'b0011 -> wb_we_o=1 with the same addr/data/sel on the bus, ack_o=2'b10 once.
- Round-robin, both ports requesting continuously for 6 transfers -> grant order 0,1,0,1,0,1. With ARB_MODE=0 -> order 0,0,0,... with port 1 starved.
- Slave never acks, TIMEOUT_CYCLES=4 -> stb dropped after 4 BUSY cycles, ack_o and err_o pulse together, rdata_o=0. Slave asserting wb_err_i instead -> same flags after 1 cycle.
- rst_n pulled low in BUSY -> wb_cyc_o/wb_stb_o 0 without waiting for a clock edge, no ack_o. After release, a pending request is re-arbitrated starting from port 0.
